misc_issue_ctrl: RTL and testbench
==================================

# misc_issue_ctrl

In-order issue controller and result sequencer for the misc execution unit (JALR, LUI, INVAL). Buffers decoded misc-class instructions in a small queue, issues the head to the combinational misc unit once its source operand is ready, registers the result for the writeback arbiter, and sequences the branch redirect produced by JALR. Sits between the dispatch stage and writeback/fetch-redirect logic.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- XLEN, 32, data/address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- flush  in  1  pipeline-wide flush
- in_valid  in  1  dispatch offers an instruction
- in_ready  out  1  controller accepts an instruction this cycle
- in_data  in  decoded_instr  decoded misc-class instruction (op, rd, rs1, rs1_val, imm, pc)
- head_rs1  out  5  rs1 index of queue head, to scoreboard
- head_rs1_busy  in  1  scoreboard: head_rs1 has a pending write
- issue_valid  out  1  head is presented to the misc unit this cycle
- issue_data  out  decoded_instr  head instruction
- misc_result  in  exec_result  combinational misc result for issue_data
- wb_valid  out  1  registered result available
- wb_ready  in  1  writeback arbiter consumes result
- wb_rd_idx  out  5  destination register
- wb_rd_val  out  XLEN  destination value
- redirect_valid  out  1  fetch redirect request
- redirect_ready  in  1  fetch accepts redirect
- redirect_target  out  XLEN  redirect PC
- count  out  $clog2(DEPTH+1)  queue occupancy
- exc_valid  out  1  illegal-instruction exception (only with MISC_CTRL_EXC_EN; else tied 0)
- exc_pc  out  XLEN  PC of faulting instruction

## Operation
- Queue: circular buffer, read/write pointers wrap modulo DEPTH; count 0..DEPTH.
- in_ready = (count < DEPTH) || pop this cycle; high in REDIR regardless of count.
- States: RUN, REDIR, HALT (HALT only with macro).
- Issue condition (RUN only): count > 0, wb slot empty or (wb_valid && wb_ready), and (op ≠ JALR or !head_rs1_busy). issue_valid = issue condition; pop on issue.
- On issue: wb register ← {misc_result.rd_idx, misc_result.rd_val}, wb_valid ← 1. rd_idx 0 still produces wb_valid (writeback ignores x0).
- JALR issue (misc_result.br_valid): redirect_target ← br_target, redirect_valid ← 1, queue cleared (all younger entries wrong-path), state → REDIR.
- REDIR: no issue; in_valid beats accepted and discarded; redirect_valid held until redirect_ready; on handshake → RUN, redirect_valid ← 0.
- INVAL: see Configuration.
- flush (any state): queue cleared, wb_valid/redirect_valid/exc_valid ← 0, state → RUN; in_ready forced 0 and any in_valid beat dropped that cycle; flush wins over every simultaneous event.
- Reset: identical to flush; all outputs 0, count 0, pointers 0.

## Timing
- Enqueue at edge N → head eligible for issue in cycle N+1 (no bypass).
- Issue cycle N → wb_valid, redirect_valid registered high from cycle N+1; issue-to-writeback latency 1.
- Back-to-back issue with wb_ready held 1: one instruction per cycle.
- Full queue with simultaneous pop and push: both occur, count unchanged.
- wb_valid held with stable data until wb_ready; no issue overwrites a pending result.
- flush in a cycle where redirect_valid/wb_valid are high: outputs remain high that cycle (registered), low from next cycle.

## Configuration
- MISC_CTRL_EXC_EN defined: INVAL at head issues with no writeback; exc_valid ← 1, exc_pc ← pc; state → HALT; HALT issues nothing, in_ready = 0 until flush. exc_valid held until flush.
- Undefined: INVAL issued as a NOP — no wb_valid, no exception, popped in one cycle; exc_valid/exc_pc tied 0; HALT state absent.

## Test plan
- Reset then LUI rd=5 imm=0x12345000 enqueued, wb_ready=1 → issue 1 cycle after enqueue; wb_valid next cycle, wb_rd_idx=5, wb_rd_val=0x12345000.
- JALR rd=1 rs1_val=0x1000 imm=0x8 pc=0x200, head_rs1_busy=1 for 3 cycles → no issue for 3 cycles; then wb_rd_val=0x204, redirect_target=0x1008; two LUIs queued behind are discarded, count=0.
- redirect_ready low 4 cycles after redirect → redirect_valid held 4 cycles, in_valid beats discarded, return to RUN on handshake.
- Fill DEPTH=4 with wb_ready=0 → in_ready=0 at count=4 with one result in wb; raise wb_ready with push same cycle → pop+push, count stays 4.
- flush with count=3, wb_valid=1, simultaneous in_valid → next cycle count=0, wb_valid=0, pushed beat dropped.
- INVAL pc=0x300: with MISC_CTRL_EXC_EN → exc_valid=1, exc_pc=0x300, in_ready=0 until flush; without → no wb_valid, following LUI issues next cycle.

Source files
------------

// File: rtl/misc_issue_ctrl_if.sv
// Shared instruction/result types and the controller's bundled port interface.
// master = dispatch/writeback/fetch side, slave = misc_issue_ctrl.
package misc_issue_pkg;
    localparam int PKG_XLEN = 32;

    typedef enum logic [1:0] {
        OP_JALR  = 2'd0,
        OP_LUI   = 2'd1,
        OP_INVAL = 2'd2
    } misc_op_e;

    typedef struct packed {
        misc_op_e              op;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [PKG_XLEN-1:0]   rs1_val;
        logic [PKG_XLEN-1:0]   imm;
        logic [PKG_XLEN-1:0]   pc;
    } decoded_instr_t;

    typedef struct packed {
        logic [4:0]            rd_idx;
        logic [PKG_XLEN-1:0]   rd_val;
        logic                  br_valid;
        logic [PKG_XLEN-1:0]   br_target;
    } exec_result_t;
endpackage

interface misc_issue_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    import misc_issue_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);

    logic            i_flush;
    logic            i_in_valid;
    logic            o_in_ready;
    decoded_instr_t  i_in_data;
    logic [4:0]      o_head_rs1;
    logic            i_head_rs1_busy;
    logic            o_issue_valid;
    decoded_instr_t  o_issue_data;
    exec_result_t    i_misc_result;
    logic            o_wb_valid;
    logic            i_wb_ready;
    logic [4:0]      o_wb_rd_idx;
    logic [XLEN-1:0] o_wb_rd_val;
    logic            o_redirect_valid;
    logic            i_redirect_ready;
    logic [XLEN-1:0] o_redirect_target;
    logic [CW-1:0]   o_count;
    logic            o_exc_valid;
    logic [XLEN-1:0] o_exc_pc;

    modport master (
        output i_flush, i_in_valid, i_in_data, i_head_rs1_busy, i_misc_result,
               i_wb_ready, i_redirect_ready,
        input  o_in_ready, o_head_rs1, o_issue_valid, o_issue_data, o_wb_valid,
               o_wb_rd_idx, o_wb_rd_val, o_redirect_valid, o_redirect_target,
               o_count, o_exc_valid, o_exc_pc
    );

    modport slave (
        input  i_flush, i_in_valid, i_in_data, i_head_rs1_busy, i_misc_result,
               i_wb_ready, i_redirect_ready,
        output o_in_ready, o_head_rs1, o_issue_valid, o_issue_data, o_wb_valid,
               o_wb_rd_idx, o_wb_rd_val, o_redirect_valid, o_redirect_target,
               o_count, o_exc_valid, o_exc_pc
    );
endinterface

// File: rtl/misc_issue_ctrl.sv
// In-order issue queue and result/redirect sequencer for the misc unit (JALR, LUI, INVAL).
// Define MISC_CTRL_EXC_EN to turn INVAL into an illegal-instruction exception that halts issue.
module misc_issue_ctrl
    import misc_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = PKG_XLEN
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    misc_issue_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIR
`ifdef MISC_CTRL_EXC_EN
        , ST_HALT
`endif
    } state_e;

    state_e          r_state, w_state_nxt;
    decoded_instr_t  r_mem [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_wb_valid;
    logic [4:0]      r_wb_idx;
    logic [XLEN-1:0] r_wb_val;
    logic            r_redir_valid;
    logic [XLEN-1:0] r_redir_target;

    decoded_instr_t  w_head;
    logic            w_has_head, w_wb_free, w_redir_done;
    logic            w_issue, w_in_ready, w_push, w_clear, w_writes;

    assign w_head       = r_mem[r_rptr];
    assign w_has_head   = (r_count != '0);
    assign w_wb_free    = !r_wb_valid || bus.i_wb_ready;
    assign w_redir_done = r_redir_valid && bus.i_redirect_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_issue    = w_has_head && w_wb_free &&
                             !(w_head.op == OP_JALR && bus.i_head_rs1_busy);
                w_in_ready = (r_count < CW'(DEPTH)) || w_issue;
                if (w_issue && bus.i_misc_result.br_valid)
                    w_state_nxt = ST_REDIR;
`ifdef MISC_CTRL_EXC_EN
                else if (w_issue && w_head.op == OP_INVAL)
                    w_state_nxt = ST_HALT;
`endif
            end
            ST_REDIR: begin
                // Wrong-path beats are swallowed while fetch is being redirected.
                w_in_ready = 1'b1;
                if (w_redir_done) w_state_nxt = ST_RUN;
            end
`ifdef MISC_CTRL_EXC_EN
            ST_HALT: w_state_nxt = ST_HALT;
`endif
            default: w_state_nxt = ST_RUN;
        endcase
        if (bus.i_flush) begin
            w_state_nxt = ST_RUN;
            w_issue     = 1'b0;
            w_in_ready  = 1'b0;
        end
    end

    // A JALR issue discards everything younger, including a same-cycle dispatch beat.
    assign w_clear  = w_issue && bus.i_misc_result.br_valid;
    assign w_push   = bus.i_in_valid && w_in_ready && (r_state == ST_RUN) && !w_clear;
    assign w_writes = w_issue && (w_head.op != OP_INVAL);

    // NOTE: queue storage is not reset; count and pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= bus.i_in_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_flush) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_idx       <= '0;
            r_wb_val       <= '0;
            r_redir_valid  <= 1'b0;
            r_redir_target <= '0;
        end else begin
            if (w_clear) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)  r_wptr <= r_wptr + PW'(1);
                if (w_issue) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_issue);
            end

            if (w_writes) begin
                r_wb_valid <= 1'b1;
                r_wb_idx   <= bus.i_misc_result.rd_idx;
                r_wb_val   <= bus.i_misc_result.rd_val;
            end else if (bus.i_wb_ready) begin
                r_wb_valid <= 1'b0;
            end

            if (w_clear) begin
                r_redir_valid  <= 1'b1;
                r_redir_target <= bus.i_misc_result.br_target;
            end else if (w_redir_done) begin
                r_redir_valid  <= 1'b0;
            end
        end
    end

`ifdef MISC_CTRL_EXC_EN
    logic            r_exc_valid;
    logic [XLEN-1:0] r_exc_pc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || bus.i_flush) begin
            r_exc_valid <= 1'b0;
            r_exc_pc    <= '0;
        end else if (w_issue && w_head.op == OP_INVAL) begin
            r_exc_valid <= 1'b1;
            r_exc_pc    <= w_head.pc;
        end
    end

    assign bus.o_exc_valid = r_exc_valid;
    assign bus.o_exc_pc    = r_exc_pc;
`else
    assign bus.o_exc_valid = 1'b0;
    assign bus.o_exc_pc    = '0;
`endif

    assign bus.o_in_ready        = w_in_ready;
    assign bus.o_head_rs1        = w_has_head ? w_head.rs1 : 5'd0;
    assign bus.o_issue_valid     = w_issue;
    assign bus.o_issue_data      = w_has_head ? w_head : '0;
    assign bus.o_wb_valid        = r_wb_valid;
    assign bus.o_wb_rd_idx       = r_wb_idx;
    assign bus.o_wb_rd_val       = r_wb_val;
    assign bus.o_redirect_valid  = r_redir_valid;
    assign bus.o_redirect_target = r_redir_target;
    assign bus.o_count           = r_count;
endmodule

// File: tb/tb_misc_issue_ctrl.sv
// Self-checking bench for misc_issue_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_misc_issue_ctrl;
    import misc_issue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    misc_issue_ctrl_if #(.DEPTH(DEPTH), .XLEN(32)) bus ();

    misc_issue_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Combinational misc execution unit.
    always_comb begin
        bus.i_misc_result = '0;
        case (bus.o_issue_data.op)
            OP_LUI: begin
                bus.i_misc_result.rd_idx = bus.o_issue_data.rd;
                bus.i_misc_result.rd_val = bus.o_issue_data.imm;
            end
            OP_JALR: begin
                bus.i_misc_result.rd_idx    = bus.o_issue_data.rd;
                bus.i_misc_result.rd_val    = bus.o_issue_data.pc + 32'd4;
                bus.i_misc_result.br_valid  = 1'b1;
                bus.i_misc_result.br_target = bus.o_issue_data.rs1_val + bus.o_issue_data.imm;
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic decoded_instr_t mk(misc_op_e op, logic [4:0] rd, logic [4:0] rs1,
                                          logic [31:0] rs1_val, logic [31:0] imm, logic [31:0] pc);
        decoded_instr_t d;
        d.op = op; d.rd = rd; d.rs1 = rs1; d.rs1_val = rs1_val; d.imm = imm; d.pc = pc;
        return d;
    endfunction

    // Stimulus drivers, applied by step().
    logic           d_flush, d_in_valid, d_busy, d_wb_ready, d_rr;
    decoded_instr_t d_in;

    // Reference model: instruction queue plus pending result/redirect/exception.
    decoded_instr_t mq[$];
    bit          m_wbv, m_rv, m_ev;
    logic [4:0]  m_wbi;
    logic [31:0] m_wbd, m_rt, m_epc;
    int          m_st;   // 0 running, 1 awaiting redirect handshake, 2 halted
    bit          s_issue, s_ready;

    task automatic model_clear();
        mq.delete();
        m_wbv = 0; m_rv = 0; m_ev = 0; m_st = 0;
    endtask

    task automatic idle();
        d_flush = 0; d_in_valid = 0; d_busy = 0; d_in = '0;
    endtask

    task automatic step();
        bit e_issue, e_ready, accept;
        decoded_instr_t h;
        bus.i_flush          = d_flush;
        bus.i_in_valid       = d_in_valid;
        bus.i_in_data        = d_in;
        bus.i_head_rs1_busy  = d_busy;
        bus.i_wb_ready       = d_wb_ready;
        bus.i_redirect_ready = d_rr;
        #4;
        e_issue = !d_flush && m_st == 0 && mq.size() > 0 && (!m_wbv || d_wb_ready) &&
                  !(mq[0].op == OP_JALR && d_busy);
        if (d_flush)        e_ready = 0;
        else if (m_st == 1) e_ready = 1;
        else if (m_st == 2) e_ready = 0;
        else                e_ready = (mq.size() < DEPTH) || e_issue;

        check("in_ready", 32'(bus.o_in_ready), 32'(e_ready));
        check("issue_valid", 32'(bus.o_issue_valid), 32'(e_issue));
        check("count", 32'(bus.o_count), 32'(mq.size()));
        if (mq.size() > 0) check("head_rs1", 32'(bus.o_head_rs1), 32'(mq[0].rs1));
        check("wb_valid", 32'(bus.o_wb_valid), 32'(m_wbv));
        if (m_wbv) begin
            check("wb_rd_idx", 32'(bus.o_wb_rd_idx), 32'(m_wbi));
            check("wb_rd_val", bus.o_wb_rd_val, m_wbd);
        end
        check("redirect_valid", 32'(bus.o_redirect_valid), 32'(m_rv));
        if (m_rv) check("redirect_target", bus.o_redirect_target, m_rt);
        check("exc_valid", 32'(bus.o_exc_valid), 32'(m_ev));
        if (m_ev) check("exc_pc", bus.o_exc_pc, m_epc);
        s_issue = bus.o_issue_valid;
        s_ready = bus.o_in_ready;

        if (d_flush) begin
            model_clear();
        end else begin
            accept = d_in_valid && e_ready && m_st == 0;
            if (m_wbv && d_wb_ready) m_wbv = 0;
            if (m_st == 1 && d_rr) begin m_rv = 0; m_st = 0; end
            if (e_issue) begin
                h = mq.pop_front();
                case (h.op)
                    OP_LUI: begin m_wbv = 1; m_wbi = h.rd; m_wbd = h.imm; end
                    OP_JALR: begin
                        m_wbv = 1; m_wbi = h.rd; m_wbd = h.pc + 32'd4;
                        m_rv = 1; m_rt = h.rs1_val + h.imm;
                        mq.delete(); accept = 0; m_st = 1;
                    end
                    default: begin
`ifdef MISC_CTRL_EXC_EN
                        m_ev = 1; m_epc = h.pc; m_st = 2;
`endif
                    end
                endcase
            end
            if (accept) mq.push_back(d_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input decoded_instr_t d);
        d_in_valid = 1; d_in = d;
        step();
        d_in_valid = 0;
    endtask

    typedef struct {
        decoded_instr_t instr;
        logic [4:0]     exp_idx;
        logic [31:0]    exp_val;
        bit             exp_redir;
        logic [31:0]    exp_target;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{mk(OP_LUI, 5'd3, 5'd0, 32'h0, 32'hABCDE000, 32'h100), 5'd3, 32'hABCDE000, 0, 32'h0};
        vecs[1] = '{mk(OP_JALR, 5'd1, 5'd2, 32'h2000, 32'h10, 32'h400), 5'd1, 32'h404, 1, 32'h2010};
        vecs[2] = '{mk(OP_JALR, 5'd0, 5'd9, 32'hFFFFFFF0, 32'h20, 32'hFFFFFFFC), 5'd0, 32'h0, 1, 32'h10};
        vecs[3] = '{mk(OP_LUI, 5'd31, 5'd0, 32'h0, 32'hFFFFF000, 32'h108), 5'd31, 32'hFFFFF000, 0, 32'h0};

        // Reset
        rst_n = 0;
        idle(); d_wb_ready = 1; d_rr = 1;
        bus.i_flush = 0; bus.i_in_valid = 0; bus.i_in_data = '0; bus.i_head_rs1_busy = 0;
        bus.i_wb_ready = 1; bus.i_redirect_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_clear();
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        check("rst_redirect_valid", 32'(bus.o_redirect_valid), 32'd0);
        check("rst_exc_valid", 32'(bus.o_exc_valid), 32'd0);

        // LUI rd=5: issue one cycle after enqueue, writeback the cycle after
        push(mk(OP_LUI, 5'd5, 5'd0, 32'h0, 32'h12345000, 32'h0));
        step();
        check("lui_issue", 32'(s_issue), 32'd1);
        check("lui_wb_valid", 32'(bus.o_wb_valid), 32'd1);
        check("lui_wb_idx", 32'(bus.o_wb_rd_idx), 32'd5);
        check("lui_wb_val", bus.o_wb_rd_val, 32'h12345000);
        step();

        // JALR stalled on a busy source, younger LUIs discarded on issue
        d_busy = 1;
        push(mk(OP_JALR, 5'd1, 5'd3, 32'h1000, 32'h8, 32'h200));
        push(mk(OP_LUI, 5'd6, 5'd0, 32'h0, 32'h6000, 32'h204));
        check("jalr_stall1", 32'(s_issue), 32'd0);
        push(mk(OP_LUI, 5'd7, 5'd0, 32'h0, 32'h7000, 32'h208));
        check("jalr_stall2", 32'(s_issue), 32'd0);
        step();
        check("jalr_stall3", 32'(s_issue), 32'd0);
        d_busy = 0;
        d_rr = 0;
        step();
        check("jalr_issue", 32'(s_issue), 32'd1);
        check("jalr_wb_val", bus.o_wb_rd_val, 32'h204);
        check("jalr_redirect_valid", 32'(bus.o_redirect_valid), 32'd1);
        check("jalr_target", bus.o_redirect_target, 32'h1008);
        check("jalr_count", 32'(bus.o_count), 32'd0);

        // Redirect held while fetch stalls; dispatch beats are swallowed
        for (int i = 0; i < 4; i++) begin
            push(mk(OP_LUI, 5'd8, 5'd0, 32'h0, 32'h8000, 32'h20C));
            check("redir_ready", 32'(s_ready), 32'd1);
            check("redir_held", 32'(bus.o_redirect_valid), 32'd1);
            check("redir_count", 32'(bus.o_count), 32'd0);
        end
        d_rr = 1;
        step();
        check("redir_done", 32'(bus.o_redirect_valid), 32'd0);
        push(mk(OP_LUI, 5'd9, 5'd0, 32'h0, 32'h9000, 32'h1008));
        step();
        check("run_after_redir", 32'(s_issue), 32'd1);
        step();

        // Fill the queue behind a stalled result, then pop+push at full
        d_wb_ready = 0;
        for (int i = 0; i < 5; i++)
            push(mk(OP_LUI, 5'(10 + i), 5'd0, 32'h0, 32'(i) << 12, 32'h0));
        check("full_count", 32'(bus.o_count), 32'd4);
        check("full_wb_valid", 32'(bus.o_wb_valid), 32'd1);
        push(mk(OP_LUI, 5'd20, 5'd0, 32'h0, 32'h14000, 32'h0));
        check("full_not_ready", 32'(s_ready), 32'd0);
        d_wb_ready = 1;
        push(mk(OP_LUI, 5'd21, 5'd0, 32'h0, 32'h15000, 32'h0));
        check("full_ready", 32'(s_ready), 32'd1);
        check("full_pop", 32'(s_issue), 32'd1);
        check("full_pushpop_count", 32'(bus.o_count), 32'd4);
        step();
        check("pre_flush_count", 32'(bus.o_count), 32'd3);

        // Flush beats a simultaneous dispatch and clears the pending result
        d_wb_ready = 0; d_flush = 1;
        push(mk(OP_LUI, 5'd22, 5'd0, 32'h0, 32'h16000, 32'h0));
        d_flush = 0;
        check("flush_count", 32'(bus.o_count), 32'd0);
        check("flush_wb_valid", 32'(bus.o_wb_valid), 32'd0);
        d_wb_ready = 1;
        step();
        check("flush_dropped", 32'(bus.o_count), 32'd0);

        // INVAL handling
        push(mk(OP_INVAL, 5'd0, 5'd0, 32'h0, 32'h0, 32'h300));
`ifdef MISC_CTRL_EXC_EN
        step();
        check("inval_exc_valid", 32'(bus.o_exc_valid), 32'd1);
        check("inval_exc_pc", bus.o_exc_pc, 32'h300);
        push(mk(OP_LUI, 5'd4, 5'd0, 32'h0, 32'h4000, 32'h304));
        check("halt_not_ready", 32'(s_ready), 32'd0);
        d_flush = 1;
        step();
        d_flush = 0;
        check("halt_flush_exc", 32'(bus.o_exc_valid), 32'd0);
`else
        push(mk(OP_LUI, 5'd4, 5'd0, 32'h0, 32'h4000, 32'h304));
        check("inval_issue", 32'(s_issue), 32'd1);
        check("inval_no_wb", 32'(bus.o_wb_valid), 32'd0);
        check("inval_no_exc", 32'(bus.o_exc_valid), 32'd0);
        step();
        check("lui_after_inval", 32'(s_issue), 32'd1);
        check("lui_after_inval_val", bus.o_wb_rd_val, 32'h4000);
`endif
        step();

        // Vector table: each instruction alone through the pipe
        d_wb_ready = 1; d_rr = 1;
        for (int v = 0; v < 4; v++) begin
            push(vecs[v].instr);
            step();
            check("vec_wb_valid", 32'(bus.o_wb_valid), 32'd1);
            check("vec_wb_idx", 32'(bus.o_wb_rd_idx), 32'(vecs[v].exp_idx));
            check("vec_wb_val", bus.o_wb_rd_val, vecs[v].exp_val);
            check("vec_redirect", 32'(bus.o_redirect_valid), 32'(vecs[v].exp_redir));
            if (vecs[v].exp_redir) check("vec_target", bus.o_redirect_target, vecs[v].exp_target);
            step();
            step();
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            d_flush    = ($urandom_range(63) == 0);
            d_in_valid = $urandom_range(1);
            d_busy     = ($urandom_range(9) < 3);
            d_wb_ready = ($urandom_range(9) < 7);
            d_rr       = $urandom_range(1);
            r = $urandom_range(7);
            d_in = mk((r == 0) ? OP_INVAL : (r < 3) ? OP_JALR : OP_LUI,
                      5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
